// File: rtl/rs_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rs_ctrl_pkg
// Shared definitions for the RS flip-flop bank controller:
//   state_t  - controller FSM states; the encoding is what led_pin[15:14] shows
//   sr_cmd_t - RS commands, encoded as {S,R}
//   NUM_CH   - number of RS cells in the bank
// -----------------------------------------------------------------------------
package rs_ctrl_pkg;

  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LATCH = 2'b01,
    ST_PULSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'b00,
    SR_RESET   = 2'b01,
    SR_SET     = 2'b10,
    SR_INVALID = 2'b11
  } sr_cmd_t;

endpackage

// File: rtl/rs_ff_bank.sv
// -----------------------------------------------------------------------------
// rs_ff_bank
// Bank of NUM_CH RS cells. A cell only reacts while its clock enable is high.
// SET forces Q to 1, RESET forces it to 0, and HOLD and INVALID keep Q.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset, clears every Q
//   ce   in   per-cell clock enable, at most one bit set at a time
//   cmd  in   {S,R} command applied to the enabled cells
//   q    out  cell outputs
// -----------------------------------------------------------------------------
module rs_ff_bank
  import rs_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ce,
  input  logic [1:0]        cmd,
  output logic [NUM_CH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ce[i]) begin
          case (cmd)
            SR_SET:   q[i] <= 1'b1;
            SR_RESET: q[i] <= 1'b0;
            default:  q[i] <= q[i];
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/rs_ff_bank_ctrl.sv
// -----------------------------------------------------------------------------
// rs_ff_bank_ctrl
// Controller for an 8-cell RS flip-flop bank. Commands come from two sources:
//   - A manual button press, which applies {S,R,channel} taken from sw_pin.
//   - An auto-scan generator. It sets and then clears each channel in turn.
// Each command runs IDLE -> LATCH -> PULSE -> DONE -> IDLE. In PULSE the
// target cell gets a clock enable for exactly one cycle.
// Optional feature: define RS_CTRL_DEBOUNCE_EN to require btn_1 to be stable
// for DB_CYCLES cycles before a level change is accepted.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   sw_pin   in   [0]=S [1]=R [4:2]=channel [7]=auto-scan enable
//   btn_1    in   raw asynchronous push button
//   led_pin  out  [7:0]=Q [8]=error [11:9]=auto pointer [12]=busy
//                 [13]=auto active [15:14]=FSM state
// -----------------------------------------------------------------------------
module rs_ff_bank_ctrl
  import rs_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int DB_CYCLES = 2000000,
  parameter int AUTO_DIV  = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw_pin,
  input  logic        btn_1,
  output logic [15:0] led_pin
);

  localparam int DIV_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

  logic              btn_meta, btn_sync, btn_level, btn_prev, press;
  logic              auto_en, tick, pending;
  logic [DIV_W-1:0]  div_cnt;
  state_t            state;
  logic              src_auto;
  logic [1:0]        cmd_sr;
  logic [2:0]        cmd_ch;
  logic [2:0]        pointer;
  logic              phase;
  logic              err;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] q;
  logic [1:0]        state_code;
  logic              busy;
  logic              unused_bits;

  assign unused_bits = &{1'b0, sw_pin[6:5], CLK_HZ[0], DB_CYCLES[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_1;
      btn_sync <= btn_meta;
    end
  end

`ifdef RS_CTRL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  // The accepted level only follows the synchronised input once the input
  // has differed from it for DB_CYCLES consecutive cycles. Any bounce back
  // to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (btn_sync == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      db_cnt   <= '0;
      db_level <= btn_sync;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign btn_level = db_level;
`else
  assign btn_level = btn_sync;
`endif

  always_ff @(posedge clk) begin
    if (rst) btn_prev <= 1'b0;
    else     btn_prev <= btn_level;
  end

  assign press = btn_level & ~btn_prev;

  // The divider runs only while auto-scan is enabled. Dropping the enable
  // restarts it from zero; the pointer and phase keep their values.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_en <= 1'b0;
      div_cnt <= '0;
    end else begin
      auto_en <= sw_pin[7];
      if (!auto_en || tick) div_cnt <= '0;
      else                  div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = auto_en && (div_cnt == DIV_W'(AUTO_DIV - 1));

  // A tick only marks a command as pending; IDLE serves it when no press
  // competes. A tick arriving in the same cycle a pending command is served
  // becomes the new pending command and is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= 1'b0;
      src_auto <= 1'b0;
      cmd_sr   <= SR_HOLD;
      cmd_ch   <= '0;
      pointer  <= '0;
      phase    <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (!auto_en)
        pending <= 1'b0;
      else if (tick)
        pending <= 1'b1;
      else if (state == ST_IDLE && !press && pending)
        pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (press) begin
            state    <= ST_LATCH;
            src_auto <= 1'b0;
          end else if (pending && auto_en) begin
            state    <= ST_LATCH;
            src_auto <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (src_auto) begin
            cmd_sr <= phase ? SR_RESET : SR_SET;
            cmd_ch <= pointer;
            phase  <= ~phase;
            if (phase) pointer <= pointer + 3'd1;
          end else begin
            cmd_sr <= {sw_pin[0], sw_pin[1]};
            cmd_ch <= sw_pin[4:2];
          end
          state <= ST_PULSE;
        end
        ST_PULSE: begin
          // The error flag is sticky. Only a valid manual command clears it.
          if (cmd_sr == SR_INVALID) err <= 1'b1;
          else if (!src_auto)       err <= 1'b0;
          state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign ce = (state == ST_PULSE) ? (NUM_CH'(1) << cmd_ch) : '0;

  rs_ff_bank u_bank (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .cmd (cmd_sr),
    .q   (q)
  );

  assign state_code = state;
  assign busy       = (state != ST_IDLE);
  assign led_pin    = {state_code, auto_en, busy, pointer, err, q};

endmodule

// File: tb/tb_rs_ff_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rs_ff_bank_ctrl
// Self-checking bench for rs_ff_bank_ctrl, built with AUTO_DIV=16.
// Expected results come from a behavioural model of the bank. They are pushed
// to a queue when a command is issued and popped when the DUT reaches DONE.
// -----------------------------------------------------------------------------
module tb_rs_ff_bank_ctrl;

  localparam int AUTO_DIV  = 16;
  localparam int DB_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw_pin;
  logic        btn_1;
  logic [15:0] led_pin;

  rs_ff_bank_ctrl #(
    .CLK_HZ    (100000000),
    .DB_CYCLES (DB_CYCLES),
    .AUTO_DIV  (AUTO_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_pin  (sw_pin),
    .btn_1   (btn_1),
    .led_pin (led_pin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] q;
    logic       err;
    logic [2:0] ptr;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q_m;
  logic       err_m;
  logic [2:0] ptr_m;
  logic       phase_m;

  function automatic logic [7:0] apply_sr(input logic [7:0] q, input logic s,
                                          input logic r, input logic [2:0] ch);
    logic [7:0] n;
    n = q;
    if (s && !r) n[ch] = 1'b1;
    if (r && !s) n[ch] = 1'b0;
    return n;
  endfunction

  task automatic model_reset();
    q_m = '0; err_m = 1'b0; ptr_m = '0; phase_m = 1'b0;
    sb.delete();
  endtask

  task automatic model_manual(input logic [7:0] sw);
    exp_t e;
    q_m   = apply_sr(q_m, sw[0], sw[1], sw[4:2]);
    err_m = sw[0] & sw[1];
    e.q = q_m; e.err = err_m; e.ptr = ptr_m;
    sb.push_back(e);
  endtask

  task automatic model_auto();
    exp_t e;
    q_m = apply_sr(q_m, !phase_m, phase_m, ptr_m);
    if (phase_m) ptr_m = ptr_m + 3'd1;
    phase_m = !phase_m;
    e.q = q_m; e.err = err_m; e.ptr = ptr_m;
    sb.push_back(e);
  endtask

  task automatic wait_state(input logic [1:0] code, input int max_cycles,
                            output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (led_pin[15:14] == code) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_btn();
    btn_1 = 1'b0;
    repeat (DB_CYCLES + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_pin = 8'h00; btn_1 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (led_pin !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_held: led_pin=%h expected 0000", led_pin);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (led_pin !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_release: led_pin=%h expected 0000", led_pin);
    end
  endtask

  task automatic test_manual();
    logic [7:0] sw_list [4];
    logic [7:0] old_q;
    exp_t       e;
    bit         found;
    // Set ch3 with the full state sequence and latency checked.
    old_q = q_m;
    sw_pin = 8'h0D;
    model_manual(8'h0D);
    btn_1 = 1'b1;
    wait_state(2'b01, 60, found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL manual_latch: LATCH not reached, state=%b", led_pin[15:14]);
    end
    @(negedge clk);
    n_checks++;
    if (led_pin[15:14] !== 2'b10 || led_pin[7:0] !== old_q) begin
      n_fail++;
      $display("[TB] FAIL manual_pulse: state=%b q=%h expected state 10 q=%h",
               led_pin[15:14], led_pin[7:0], old_q);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (led_pin[15:14] !== 2'b11 || led_pin[8:0] !== {e.err, e.q}) begin
      n_fail++;
      $display("[TB] FAIL manual_done: state=%b err/q=%h expected state 11 err/q=%h",
               led_pin[15:14], led_pin[8:0], {e.err, e.q});
    end
    @(negedge clk);
    n_checks++;
    if (led_pin[15:12] !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL manual_idle: state/busy=%b expected 0000", led_pin[15:12]);
    end
    release_btn();

    // Set ch5, clear ch3, hold ch5, set ch7.
    sw_list = '{8'h15, 8'h0E, 8'h14, 8'h1D};
    foreach (sw_list[k]) begin
      sw_pin = sw_list[k];
      model_manual(sw_list[k]);
      btn_1 = 1'b1;
      wait_state(2'b11, 60, found);
      e = sb.pop_front();
      n_checks++;
      if (!found || led_pin[8:0] !== {e.err, e.q}) begin
        n_fail++;
        $display("[TB] FAIL manual_cmd_%0d: found=%0d err/q=%h expected %h",
                 k, found, led_pin[8:0], {e.err, e.q});
      end
      release_btn();
    end
  endtask

  task automatic test_invalid();
    logic [7:0] sw_list [3];
    exp_t       e;
    bit         found;
    // SR=11 on ch0, then SR=11 on ch7 (error stays), then a valid R on ch0.
    sw_list = '{8'h03, 8'h1F, 8'h02};
    foreach (sw_list[k]) begin
      sw_pin = sw_list[k];
      model_manual(sw_list[k]);
      btn_1 = 1'b1;
      wait_state(2'b11, 60, found);
      e = sb.pop_front();
      n_checks++;
      if (!found || led_pin[8:0] !== {e.err, e.q}) begin
        n_fail++;
        $display("[TB] FAIL invalid_cmd_%0d: found=%0d err/q=%h expected %h",
                 k, found, led_pin[8:0], {e.err, e.q});
      end
      release_btn();
    end
  endtask

  task automatic test_auto();
    exp_t e;
    bit   found;
    int   t_prev;
    sw_pin = 8'h80;
    t_prev = cyc;
    for (int k = 0; k < 2 * 8; k++) begin
      model_auto();
      wait_state(2'b11, 2 * AUTO_DIV + 8, found);
      e = sb.pop_front();
      n_checks++;
      if (!found || led_pin[13] !== 1'b1 || led_pin[11:9] !== e.ptr ||
          led_pin[8:0] !== {e.err, e.q}) begin
        n_fail++;
        $display("[TB] FAIL auto_cmd_%0d: found=%0d led=%h expected ptr=%0d err/q=%h",
                 k, found, led_pin, e.ptr, {e.err, e.q});
      end
      // The first command waits for the enable flop, AUTO_DIV divider cycles,
      // pending, LATCH and PULSE. After that, commands follow every AUTO_DIV.
      n_checks++;
      if ((cyc - t_prev) !== ((k == 0) ? AUTO_DIV + 4 : AUTO_DIV)) begin
        n_fail++;
        $display("[TB] FAIL auto_period_%0d: got %0d cycles expected %0d",
                 k, cyc - t_prev, (k == 0) ? AUTO_DIV + 4 : AUTO_DIV);
      end
      t_prev = cyc;
    end
    n_checks++;
    if (led_pin[11:9] !== 3'd0 || led_pin[7:0] !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL auto_wrap: ptr=%0d q=%h expected ptr 0 q 00",
               led_pin[11:9], led_pin[7:0]);
    end
    sw_pin = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if (led_pin[13] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL auto_off: led_pin[13]=%b expected 0", led_pin[13]);
    end
  endtask

`ifndef RS_CTRL_DEBOUNCE_EN
  task automatic test_back_to_back();
    exp_t e;
    bit   found;
    bit   stray;
    // A first auto command aligns the bench to the divider.
    sw_pin = 8'h80;
    model_auto();
    wait_state(2'b11, AUTO_DIV + 10, found);
    e = sb.pop_front();
    n_checks++;
    if (!found || led_pin[8:0] !== {e.err, e.q}) begin
      n_fail++;
      $display("[TB] FAIL collide_align: found=%0d err/q=%h expected %h",
               found, led_pin[8:0], {e.err, e.q});
    end
    // The next tick falls 12 cycles after this DONE. Raising the button now
    // lets the 2-flop synchroniser deliver the press in that same cycle.
    repeat (10) @(negedge clk);
    sw_pin = 8'h99;
    btn_1  = 1'b1;
    model_manual(8'h99);
    model_auto();
    wait_state(2'b01, 10, found);
    btn_1 = 1'b0;
    wait_state(2'b11, 10, found);
    e = sb.pop_front();
    n_checks++;
    if (!found || led_pin[11:9] !== 3'd0 || led_pin[8:0] !== {e.err, e.q}) begin
      n_fail++;
      $display("[TB] FAIL collide_manual: found=%0d led=%h expected err/q=%h",
               found, led_pin, {e.err, e.q});
    end
    // Raising the button in the auto LATCH produces a press while busy.
    wait_state(2'b01, 10, found);
    btn_1 = 1'b1;
    wait_state(2'b11, 10, found);
    e = sb.pop_front();
    n_checks++;
    if (!found || led_pin[11:9] !== e.ptr || led_pin[8:0] !== {e.err, e.q}) begin
      n_fail++;
      $display("[TB] FAIL collide_auto: found=%0d led=%h expected ptr=%0d err/q=%h",
               found, led_pin, e.ptr, {e.err, e.q});
    end
    sw_pin = 8'h19;
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (led_pin[15:14] !== 2'b00) stray = 1'b1;
    end
    n_checks++;
    if (stray || led_pin[7:0] !== q_m) begin
      n_fail++;
      $display("[TB] FAIL busy_press_dropped: stray=%0d q=%h expected q=%h",
               stray, led_pin[7:0], q_m);
    end
    release_btn();
  endtask
`endif

  task automatic test_reset_mid_pulse();
    exp_t e;
    bit   found;
    sw_pin = 8'h8D;
    btn_1  = 1'b1;
    wait_state(2'b10, 60, found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL rst_pulse_reach: PULSE not reached, state=%b", led_pin[15:14]);
    end
    rst = 1'b1; btn_1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (led_pin !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_pulse: led_pin=%h expected 0000", led_pin);
    end
    @(negedge clk);
    rst = 1'b0; sw_pin = 8'h00;
    model_reset();
    repeat (DB_CYCLES + 4) @(negedge clk);
    sw_pin = 8'h11;
    model_manual(8'h11);
    btn_1 = 1'b1;
    wait_state(2'b11, 60, found);
    e = sb.pop_front();
    n_checks++;
    if (!found || led_pin[11:0] !== {e.ptr, e.err, e.q}) begin
      n_fail++;
      $display("[TB] FAIL post_reset_cmd: found=%0d led=%h expected ptr/err/q=%h",
               found, led_pin, {e.ptr, e.err, e.q});
    end
    release_btn();
  endtask

`ifdef RS_CTRL_DEBOUNCE_EN
  task automatic test_debounce();
    bit stray;
    sw_pin = 8'h19;
    btn_1  = 1'b1;
    repeat (5) @(negedge clk);
    btn_1 = 1'b0;
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (led_pin[15:14] !== 2'b00) stray = 1'b1;
    end
    n_checks++;
    if (stray || led_pin[7:0] !== q_m) begin
      n_fail++;
      $display("[TB] FAIL glitch_rejected: stray=%0d q=%h expected %h",
               stray, led_pin[7:0], q_m);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_invalid();
    test_auto();
`ifndef RS_CTRL_DEBOUNCE_EN
    test_back_to_back();
`endif
    test_reset_mid_pulse();
`ifdef RS_CTRL_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
